// File: rtl/serial_alu_sequencer.sv
// Bit-serial sequencer for an external 1-bit ALU cell.
// A word-level request is latched. Operand bits are then presented LSB first,
// one bit per clock, together with the op select and the running carry. The
// cell's F output is shifted into a result register. Its carry-out is fed back
// as the carry-in for the next bit. Completion is signalled with a one-cycle
// Done pulse.
module serial_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             CarryInit,
  output logic             AluS1,
  output logic             AluS0,
  output logic             AluA,
  output logic             AluB,
  output logic             AluCarryIn,
  input  logic             AluF,
  input  logic             AluCarryOut,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryFinal,
  output logic             Zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cf_q, cf_d;
  logic             zero_q, zero_d;

  // Partial result after the bit currently on the cell has been captured.
  logic [WIDTH-1:0] res_shifted;
  assign res_shifted = {AluF, res_sh_q[WIDTH-1:1]};

  // Next-state and datapath update for all sequencer registers.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cf_d     = cf_q;
    zero_d   = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (Start) begin
          op_d     = S;
          a_sh_d   = OpA;
          b_sh_d   = OpB;
          res_sh_d = '0;
          cnt_d    = '0;
          // Increment forces bit-0 carry to 1. Add uses the caller's carry.
          // Bitwise ops start with 0.
          unique case (S)
            2'b10:   carry_d = 1'b1;
            2'b11:   carry_d = CarryInit;
            default: carry_d = 1'b0;
          endcase
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        res_sh_d = res_shifted;
        carry_d  = AluCarryOut;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the word and its flags in the same edge.
          result_d = res_shifted;
          cf_d     = AluCarryOut;
          zero_d   = ~|res_shifted;
          cnt_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        // A Start seen here is dropped on purpose. Requests are not queued.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous clear of every architectural value.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cf_q     <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cf_q     <= cf_d;
      zero_q   <= zero_d;
    end
  end

  // The cell sees the op at all times. Its data and carry lines are quiet
  // outside SHIFT.
  assign AluS1      = op_q[1];
  assign AluS0      = op_q[0];
  assign AluA       = busy_q & a_sh_q[0];
  assign AluB       = busy_q & b_sh_q[0];
  assign AluCarryIn = busy_q & carry_q;

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Result     = result_q;
  assign CarryFinal = cf_q;
  assign Zero       = zero_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer. It includes a behavioural model of the 1-bit ALU cell.
module tb_serial_alu_sequencer;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         ResetN;
  logic         Start;
  logic [1:0]   S;
  logic [W-1:0] OpA, OpB;
  logic         CarryInit;
  logic         AluS1, AluS0, AluA, AluB, AluCarryIn;
  logic         AluF, AluCarryOut;
  logic         Busy, Done, CarryFinal, Zero;
  logic [W-1:0] Result;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .S(S), .OpA(OpA), .OpB(OpB),
    .CarryInit(CarryInit), .AluS1(AluS1), .AluS0(AluS0), .AluA(AluA), .AluB(AluB),
    .AluCarryIn(AluCarryIn), .AluF(AluF), .AluCarryOut(AluCarryOut),
    .Busy(Busy), .Done(Done), .Result(Result), .CarryFinal(CarryFinal), .Zero(Zero)
  );

  // 1-bit ALU cell: the ops 00 and 01 force carry-out low.
  always_comb begin
    AluF = 1'b0;
    AluCarryOut = 1'b0;
    case ({AluS1, AluS0})
      2'b00: AluF = AluA & ~AluB;
      2'b01: AluF = ~AluA;
      2'b10: begin
        AluF = AluA ^ AluCarryIn;
        AluCarryOut = AluA & AluCarryIn;
      end
      default: begin
        AluF = AluA ^ AluB ^ AluCarryIn;
        AluCarryOut = (AluA & AluB) | (AluCarryIn & (AluA ^ AluB));
      end
    endcase
  end

  typedef struct {
    logic [1:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         cf;
    logic         z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin);
    @(negedge Clock);
    S = s; OpA = a; OpB = b; CarryInit = cin; Start = 1'b1;
    @(negedge Clock);  // the edge that accepted the request has passed
    Start = 1'b0;
  endtask

  // Run one operation and check its latency, its Done pulse, the result flags and the cell drive.
  task automatic run_vec(input vec_t v);
    int busy_cnt;
    int done_idx;
    logic first_cin;
    logic exp_cin;
    busy_cnt = 0;
    done_idx = 0;
    start_op(v.s, v.a, v.b, v.cin);
    first_cin = AluCarryIn;
    for (int idx = 1; idx <= 20; idx++) begin
      if (Busy) busy_cnt++;
      if (Done) begin
        done_idx = idx;
        break;
      end
      @(negedge Clock);
    end
    exp_cin = (v.s == 2'b10) ? 1'b1 : ((v.s == 2'b11) ? v.cin : 1'b0);
    check("bit0_carry_in", 32'(first_cin), 32'(exp_cin));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("done_latency", 32'(done_idx), 32'(W + 1));
    check("result", 32'(Result), 32'(v.res));
    check("carry_final", 32'(CarryFinal), 32'(v.cf));
    check("zero", 32'(Zero), 32'(v.z));
    check("alu_bits_idle", 32'({AluA, AluB, AluCarryIn}), 32'(0));
    check("alu_sel_held", 32'({AluS1, AluS0}), 32'(v.s));
    $display("op s=%b a=0x%02h b=0x%02h cin=%b -> result=0x%02h cf=%b z=%b done_at=%0d",
             v.s, v.a, v.b, v.cin, Result, CarryFinal, Zero, done_idx);
    @(negedge Clock);
    check("done_single_pulse", 32'(Done), 32'(0));
  endtask

  initial begin
    int done_cnt;
    int busy_after;

    vecs[0] = '{2'b11, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{2'b11, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 8'h7F, 8'h55, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{2'b00, 8'hF0, 8'h3C, 1'b1, 8'hC0, 1'b0, 1'b0};
    vecs[6] = '{2'b01, 8'hA5, 8'hFF, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[7] = '{2'b11, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};

    ResetN = 1'b0; Start = 1'b0; S = 2'b11; OpA = '1; OpB = '1; CarryInit = 1'b1;
    repeat (2) @(negedge Clock);
    check("rst_busy", 32'(Busy), 32'(0));
    check("rst_done", 32'(Done), 32'(0));
    check("rst_result", 32'(Result), 32'(0));
    check("rst_zero", 32'(Zero), 32'(1));
    check("rst_alu", 32'({AluS1, AluS0, AluA, AluB, AluCarryIn}), 32'(0));
    ResetN = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // A Start pulse in mid-operation and another in the Done cycle are both dropped.
    done_cnt = 0;
    start_op(2'b11, 8'h5A, 8'h3C, 1'b0);
    for (int idx = 1; idx <= 14; idx++) begin
      if (idx == 3) begin S = 2'b00; OpA = 8'hFF; OpB = 8'h00; Start = 1'b1; end
      if (idx == 4) Start = 1'b0;
      if (Done) begin
        done_cnt++;
        Start = 1'b1;
      end else if (idx != 3) begin
        Start = 1'b0;
      end
      @(negedge Clock);
    end
    Start = 1'b0;
    busy_after = 0;
    repeat (4) begin
      if (Busy) busy_after++;
      @(negedge Clock);
    end
    check("ignore_result", 32'(Result), 32'(8'h96));
    check("ignore_done_count", 32'(done_cnt), 32'(1));
    check("ignore_no_restart", 32'(busy_after), 32'(0));
    $display("ignored-start seq -> result=0x%02h done_pulses=%0d", Result, done_cnt);

    // An asynchronous reset in mid-add clears everything without waiting for a clock edge.
    start_op(2'b11, 8'hFF, 8'h01, 1'b0);
    repeat (3) @(negedge Clock);
    #2 ResetN = 1'b0;
    #1;
    check("arst_busy", 32'(Busy), 32'(0));
    check("arst_done", 32'(Done), 32'(0));
    check("arst_result", 32'(Result), 32'(0));
    check("arst_cf", 32'(CarryFinal), 32'(0));
    check("arst_zero", 32'(Zero), 32'(1));
    check("arst_alu", 32'({AluS1, AluS0, AluA, AluB, AluCarryIn}), 32'(0));
    $display("async reset mid-op -> busy=%b result=0x%02h zero=%b", Busy, Result, Zero);
    @(negedge Clock);
    ResetN = 1'b1;
    repeat (2) @(negedge Clock);
    check("post_rst_idle", 32'(Busy), 32'(0));
    run_vec('{2'b11, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_alu_sequencer.md
Name: serial_alu_sequencer

Overview:
Bit-serial controller that drives the team's 1-bit ALU cell to perform WIDTH-bit operations, one bit per clock, LSB first. It latches a word-level request, presents operand bits, select lines and carry to the external 1-bit ALU, and registers the cell's carry-out back as the next bit's carry-in. It also shifts each sampled F bit into a result register and reports completion with a Done pulse. It sits directly upstream of, and consumes the outputs of, the 1-bit ALU cell.

Parameters:
WIDTH, 8, operand/result word width in bits (>= 2)

Ports:
Clock  input  1  system clock, rising edge
ResetN  input  1  asynchronous active-low reset
Start  input  1  request strobe, sampled only in IDLE
S  input  2  op select: 00 A&~B, 01 ~A, 10 A plus 1, 11 A plus B plus CarryInit
OpA  input  WIDTH  operand A
OpB  input  WIDTH  operand B
CarryInit  input  1  word carry-in, used only for S=11
AluS1  output  1  select bit 1 to ALU cell
AluS0  output  1  select bit 0 to ALU cell
AluA  output  1  current A bit to ALU cell
AluB  output  1  current B bit to ALU cell
AluCarryIn  output  1  current carry to ALU cell
AluF  input  1  ALU cell function output (combinational)
AluCarryOut  input  1  ALU cell carry out (combinational)
Busy  output  1  high while bits are being processed
Done  output  1  one-cycle completion pulse
Result  output  WIDTH  completed word, held until next accepted Start
CarryFinal  output  1  carry out of bit WIDTH-1
Zero  output  1  Result == 0

Behaviour:
- Interface fixed: one clock (Clock); reset asynchronous, active-low (ResetN).
- Reset (any time, including mid-operation): state IDLE; Busy=0, Done=0, Result=0, CarryFinal=0, Zero=1; latched op=00, operand shift regs=0, carry reg=0, bit counter=0; AluS1/AluS0/AluA/AluB/AluCarryIn=0.
- States: IDLE, SHIFT, DONE.
- IDLE: Start=1 at edge k -> latch S, OpA, OpB into shift regs; load carry reg with 1 if S=10, CarryInit if S=11, else 0; counter=0; go to SHIFT.
- Start while in SHIFT or DONE is ignored and not queued.
- SHIFT: AluS1/AluS0 = latched op; AluA/AluB = operand bit[counter] (LSB first); AluCarryIn = carry reg. Each edge: shift AluF into result MSB (shift right); carry reg <= AluCarryOut; counter++.
- The edge capturing bit WIDTH-1 (edge k+WIDTH) also loads Result, sets CarryFinal = AluCarryOut, and moves to DONE.
- DONE: Done=1 for exactly one cycle (the cycle after edge k+WIDTH), then IDLE. Total latency: Start edge to Done high = WIDTH cycles.
- Busy = (state == SHIFT); Busy is 0 in the Done cycle.
- Outside SHIFT: AluA/AluB/AluCarryIn driven 0; AluS1/AluS0 hold the latched op.
- Result, CarryFinal and Zero update only on completion. Aborted (reset) operations never update them except by clearing.
- Ops 00/01: the ALU cell forces carry-out 0, so CarryFinal=0. The block does not special-case this.
- Op 10: the word increments because bit-0 carry is forced to 1. OpB is latched but not used.
- Wrap-around: results are modulo 2^WIDTH. CarryFinal reports overflow for 10/11.

Test Plan:
- WIDTH=8, S=11, OpA=0x5A, OpB=0x3C, CarryInit=0 -> Result=0x96, CarryFinal=0, Zero=0, Busy high 8 cycles, Done high 8 cycles after Start edge for 1 cycle.
- S=11, OpA=0xFF, OpB=0x01, CarryInit=0 -> Result=0x00, CarryFinal=1, Zero=1. Repeat with OpA=0x10, OpB=0x20, CarryInit=1 -> Result=0x31, CarryFinal=0.
- S=10, OpA=0x7F -> Result=0x80, CarryFinal=0. S=10, OpA=0xFF -> Result=0x00, CarryFinal=1, Zero=1.
- S=00, OpA=0xF0, OpB=0x3C -> Result=0xC0, CarryFinal=0. S=01, OpA=0xA5 -> Result=0x5A, CarryFinal=0.
- Start re-pulsed at cycle 3 of an op with different operands -> ignored; original Result delivered, single Done pulse.
- ResetN low at cycle 4 of an add -> all outputs go to reset values immediately (asynchronously). After release, a new Start S=11, 0x01+0x01 -> Result=0x02 with normal latency.
